// File: rtl/mem_noc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_noc_arb_pkg
// Memory NoC request/response types and arbiter defaults.
// Rev     : 1.0
// ============================================================================
package mem_noc_arb_pkg;

    localparam int MEM_ARB_NUM_REQ         = 2;
    localparam int MEM_ARB_MAX_OUTSTANDING = 4;
    localparam int MEM_ARB_ID_MAX_W        = 3;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

    // Wide enough to tag up to eight requesters.
    typedef logic [MEM_ARB_ID_MAX_W-1:0] mem_arb_id_t;

    // Single-step modulo for an index known to be below 2*n.
    function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_noc_id_fifo.sv
`default_nettype none
// ============================================================================
// Module : mem_noc_id_fifo
// In-order tag FIFO with pointer-wrap full/empty and an occupancy count.
// Rev    : 1.0
// ============================================================================
module mem_noc_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/mem_noc_arb.sv
`default_nettype none
// ============================================================================
// Module : mem_noc_arb
// Round-robin arbiter sharing one memory channel; routes in-order responses.
// Rev    : 1.0
// ============================================================================
module mem_noc_arb
    import mem_noc_arb_pkg::*;
#(
    parameter int NUM_REQ         = MEM_ARB_NUM_REQ,
    parameter int MAX_OUTSTANDING = MEM_ARB_MAX_OUTSTANDING
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic [NUM_REQ-1:0]                s_req_valid_i,
    output logic [NUM_REQ-1:0]                s_req_ready_o,
    input  mem_req_t [NUM_REQ-1:0]            s_req_i,
    output logic [NUM_REQ-1:0]                s_resp_valid_o,
    input  logic [NUM_REQ-1:0]                s_resp_ready_i,
    output mem_resp_t                         s_resp_o,
    output logic                              m_req_valid_o,
    input  logic                              m_req_ready_i,
    output mem_req_t                          m_req_o,
    input  logic                              m_resp_valid_i,
    output logic                              m_resp_ready_o,
    input  mem_resp_t                         m_resp_i,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
    output logic                              err_orphan_o
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] gnt_idx, scan_idx, rr_next;
    logic            gnt_found;
    logic            m_req_valid_q, m_req_valid_d;
    mem_req_t        m_req_q, m_req_d;
    logic            can_accept, accept;
    logic            fifo_full, fifo_empty, resp_pop;
    logic [ID_W-1:0] head;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        scan_idx  = rr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'(rr_wrap(32'(rr_q) + 32'(k), NUM_REQ));
            if (!gnt_found && s_req_valid_i[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    // The full check uses the registered count, so a same-cycle pop never opens a slot.
    assign can_accept = (~m_req_valid_q | m_req_ready_i) & ~fifo_full;
    assign accept     = gnt_found & can_accept;
    assign rr_next    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    always_comb begin
        s_req_ready_o = '0;
        if (accept) s_req_ready_o[gnt_idx] = 1'b1;
    end

    always_comb begin
        m_req_valid_d = m_req_valid_q;
        m_req_d       = m_req_q;
        rr_d          = rr_q;
        if (accept) begin
            m_req_valid_d = 1'b1;
            m_req_d       = s_req_i[gnt_idx];
            rr_d          = rr_next;
        end else if (m_req_ready_i) begin
            m_req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            m_req_valid_q <= 1'b0;
            m_req_q       <= '0;
            rr_q          <= '0;
        end else begin
            m_req_valid_q <= m_req_valid_d;
            m_req_q       <= m_req_d;
            rr_q          <= rr_d;
        end
    end

    assign m_req_valid_o = m_req_valid_q;
    assign m_req_o       = m_req_q;

    mem_noc_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (accept),
        .wdata_i (gnt_idx),
        .pop_i   (resp_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    // With nothing outstanding the response is an orphan: drain it and flag it.
    always_comb begin
        s_resp_valid_o = '0;
        m_resp_ready_o = 1'b1;
        if (!fifo_empty) begin
            s_resp_valid_o[head] = m_resp_valid_i;
            m_resp_ready_o       = s_resp_ready_i[head];
        end
    end

    assign s_resp_o     = m_resp_i;
    assign resp_pop     = m_resp_valid_i & m_resp_ready_o & ~fifo_empty;
    assign err_orphan_o = m_resp_valid_i & fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_mem_noc_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_noc_arb
// Randomized scoreboard bench for mem_noc_arb against a queue-based model.
// Rev    : 1.0
// ============================================================================
module tb_mem_noc_arb;
    import mem_noc_arb_pkg::*;

    localparam int NR = 3;
    localparam int MO = 4;
    localparam int OW = $clog2(MO) + 1;

    logic                clk_i = 1'b0;
    logic                rstn_i;
    logic [NR-1:0]       s_req_valid_i;
    logic [NR-1:0]       s_req_ready_o;
    mem_req_t [NR-1:0]   s_req_i;
    logic [NR-1:0]       s_resp_valid_o;
    logic [NR-1:0]       s_resp_ready_i;
    mem_resp_t           s_resp_o;
    logic                m_req_valid_o;
    logic                m_req_ready_i;
    mem_req_t            m_req_o;
    logic                m_resp_valid_i;
    logic                m_resp_ready_o;
    mem_resp_t           m_resp_i;
    logic [OW-1:0]       outstanding_o;
    logic                err_orphan_o;

    mem_noc_arb #(
        .NUM_REQ         (NR),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .s_req_valid_i  (s_req_valid_i),
        .s_req_ready_o  (s_req_ready_o),
        .s_req_i        (s_req_i),
        .s_resp_valid_o (s_resp_valid_o),
        .s_resp_ready_i (s_resp_ready_i),
        .s_resp_o       (s_resp_o),
        .m_req_valid_o  (m_req_valid_o),
        .m_req_ready_i  (m_req_ready_i),
        .m_req_o        (m_req_o),
        .m_resp_valid_i (m_resp_valid_i),
        .m_resp_ready_o (m_resp_ready_o),
        .m_resp_i       (m_resp_i),
        .outstanding_o  (outstanding_o),
        .err_orphan_o   (err_orphan_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NR-1:0] sready;
        logic [NR-1:0] srvalid;
        logic          mrready;
        logic          orphan;
        int            outst;
        logic          mvalid;
    } cyc_t;

    typedef struct {
        int        owner;
        mem_resp_t resp;
    } resp_exp_t;

    cyc_t      cyc_q[$];
    mem_req_t  exp_mreq[$];
    resp_exp_t exp_resp[$];

    // Reference state: who is owed a response, what sits in the output slot,
    // the priority pointer, and a memory that answers in request order.
    int        rr_m;
    bit        mvalid_m;
    mem_req_t  mreq_m;
    int        owner_m[$];
    mem_resp_t mem_q[$];
    mem_req_t  pend[NR][$];
    int        seq;

    int checks = 0;
    int errors = 0;

    cyc_t      mc;
    mem_req_t  em;
    resp_exp_t er;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic mem_resp_t mem_answer(input mem_req_t r);
        mem_resp_t a;
        a.rdata = r.addr ^ r.wdata ^ 32'h5A5A_0000;
        a.err   = r.addr[0];
        return a;
    endfunction

    task automatic drive_cycle(input int p_new, input logic [NR-1:0] mask, input int p_mrdy,
                               input int p_resp, input int p_srdy, input bit orphan_en);
        cyc_t      c;
        resp_exp_t re;
        mem_req_t  r;
        int        win;
        int        head;
        bit        can_acc;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (mask[i] && pend[i].size() < 2 && int'($urandom_range(99)) < p_new) begin
                r.addr  = {8'(i), 24'(seq)};
                r.we    = 1'($urandom);
                r.wdata = $urandom;
                r.be    = 4'($urandom);
                seq++;
                pend[i].push_back(r);
            end
        end
        for (int i = 0; i < NR; i++) begin
            s_req_valid_i[i] = (pend[i].size() > 0);
            s_req_i[i]       = (pend[i].size() > 0) ? pend[i][0] : '0;
            s_resp_ready_i[i] = (int'($urandom_range(99)) < p_srdy);
        end
        m_req_ready_i  = (int'($urandom_range(99)) < p_mrdy);
        m_resp_i.rdata = $urandom;
        m_resp_i.err   = 1'($urandom);
        if (mem_q.size() > 0 && int'($urandom_range(99)) < p_resp) begin
            m_resp_valid_i = 1'b1;
            m_resp_i       = mem_q[0];
        end else if (orphan_en && owner_m.size() == 0 && mem_q.size() == 0) begin
            m_resp_valid_i = 1'b1;
        end else begin
            m_resp_valid_i = 1'b0;
        end

        c.outst   = owner_m.size();
        c.mvalid  = mvalid_m;
        c.sready  = '0;
        c.srvalid = '0;
        c.mrready = 1'b1;
        c.orphan  = m_resp_valid_i && (owner_m.size() == 0);
        if (owner_m.size() > 0) begin
            head      = owner_m[0];
            c.mrready = s_resp_ready_i[head];
            if (m_resp_valid_i) c.srvalid[head] = 1'b1;
        end
        can_acc = (!mvalid_m || m_req_ready_i) && (owner_m.size() < MO);
        win = -1;
        for (int k = 0; k < NR; k++) begin
            if (win < 0 && s_req_valid_i[(rr_m + k) % NR]) win = (rr_m + k) % NR;
        end
        if (win >= 0 && can_acc) c.sready[win] = 1'b1;
        cyc_q.push_back(c);

        if (m_resp_valid_i && c.mrready && owner_m.size() > 0) begin
            re.owner = owner_m.pop_front();
            re.resp  = mem_q.pop_front();
            exp_resp.push_back(re);
        end
        if (mvalid_m && m_req_ready_i) mem_q.push_back(mem_answer(mreq_m));
        if (c.sready != '0) begin
            mreq_m   = pend[win].pop_front();
            mvalid_m = 1'b1;
            exp_mreq.push_back(mreq_m);
            owner_m.push_back(win);
            rr_m = (win + 1) % NR;
        end else if (m_req_ready_i) begin
            mvalid_m = 1'b0;
        end
    endtask

    task automatic run(input int n, input int p_new, input logic [NR-1:0] mask, input int p_mrdy,
                       input int p_resp, input int p_srdy, input bit orphan_en);
        for (int j = 0; j < n; j++) drive_cycle(p_new, mask, p_mrdy, p_resp, p_srdy, orphan_en);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_outstanding"}, 96'(outstanding_o), 96'(0));
        chk({tag, "_m_req_valid"}, 96'(m_req_valid_o), 96'(0));
        chk({tag, "_m_req"},       96'(m_req_o), 96'(0));
        chk({tag, "_s_req_ready"}, 96'(s_req_ready_o), 96'(0));
        chk({tag, "_s_resp_valid"}, 96'(s_resp_valid_o), 96'(0));
        chk({tag, "_err_orphan"},  96'(err_orphan_o), 96'(0));
    endtask

    task automatic reset_midrun();
        @(negedge clk_i);
        #2;
        s_req_valid_i  = '0;
        m_resp_valid_i = 1'b0;
        rstn_i         = 1'b0;
        #1;
        check_reset_values("midrst");
        rr_m     = 0;
        mvalid_m = 1'b0;
        mreq_m   = '0;
        owner_m.delete();
        mem_q.delete();
        cyc_q.delete();
        exp_mreq.delete();
        exp_resp.delete();
        @(posedge clk_i);
        @(negedge clk_i);
        #2;
        rstn_i = 1'b1;
    endtask

    always @(negedge clk_i) begin
        if (rstn_i && cyc_q.size() > 0) begin
            mc = cyc_q.pop_front();
            chk("s_req_ready",  96'(s_req_ready_o),  96'(mc.sready));
            chk("s_resp_valid", 96'(s_resp_valid_o), 96'(mc.srvalid));
            chk("m_resp_ready", 96'(m_resp_ready_o), 96'(mc.mrready));
            chk("err_orphan",   96'(err_orphan_o),   96'(mc.orphan));
            chk("outstanding",  96'(outstanding_o),  96'(mc.outst));
            chk("m_req_valid",  96'(m_req_valid_o),  96'(mc.mvalid));
            if (m_req_valid_o && m_req_ready_i) begin
                chk("m_req_expected", 96'(exp_mreq.size() > 0), 96'(1));
                if (exp_mreq.size() > 0) begin
                    em = exp_mreq.pop_front();
                    chk("m_req", 96'(m_req_o), 96'(em));
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (s_resp_valid_o[i] && s_resp_ready_i[i]) begin
                    chk("resp_expected", 96'(exp_resp.size() > 0), 96'(1));
                    if (exp_resp.size() > 0) begin
                        er = exp_resp.pop_front();
                        chk("resp_owner", 96'(i), 96'(er.owner));
                        chk("s_resp", 96'(s_resp_o), 96'(er.resp));
                    end
                end
            end
        end
    end

    initial begin
        rstn_i         = 1'b0;
        s_req_valid_i  = '0;
        s_req_i        = '0;
        s_resp_ready_i = '0;
        m_req_ready_i  = 1'b0;
        m_resp_valid_i = 1'b0;
        m_resp_i       = '0;
        rr_m     = 0;
        mvalid_m = 1'b0;
        mreq_m   = '0;
        seq      = 1;
        #12;
        check_reset_values("rst");
        @(negedge clk_i);
        rstn_i = 1'b1;

        run(40,  100, 3'b001, 100,  30, 100, 1'b0);
        run(150, 100, 3'b111, 100, 100, 100, 1'b0);
        run(400,  60, 3'b111,  60,  50,  70, 1'b0);
        run(100, 100, 3'b111,  20,  60,  50, 1'b0);
        run(100,  50, 3'b011, 100,  40, 100, 1'b1);
        run(10,  100, 3'b111, 100,   0, 100, 1'b0);
        reset_midrun();
        run(200,  70, 3'b111,  70,  60,  60, 1'b1);
        run(100,   0, 3'b000, 100, 100, 100, 1'b0);

        @(negedge clk_i);
        #2;
        chk("drain_m_req_queue", 96'(exp_mreq.size()), 96'(0));
        chk("drain_resp_queue",  96'(exp_resp.size()), 96'(0));
        chk("drain_outstanding", 96'(outstanding_o), 96'(0));
        chk("drain_m_req_valid", 96'(m_req_valid_o), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
